// File: rtl/median_frame_ctrl_if.sv
// median_frame_ctrl_if: handshake and memory bus between the frame sequencer and its environment.
// Ports (seen from the controller through the master modport):
//   in : frameStart, pixelValid, pixelData, filterXAddr, filterYAddr, filterDone,
//        xValid, yValid, histogramCleared
//   out: busy, frameDone, timeoutError, overrun, memXAddress, memYAddress, memWrite,
//        memDataIn, filterStart, readHistogram, clearHistogram
interface median_frame_ctrl_if #(parameter int ADDR_W = 8);
  logic frameStart, pixelValid, pixelData;
  logic busy, frameDone, timeoutError, overrun;
  logic [ADDR_W-1:0] memXAddress, memYAddress;
  logic memWrite, memDataIn;
  logic [ADDR_W-1:0] filterXAddr, filterYAddr;
  logic filterStart, filterDone;
  logic readHistogram, clearHistogram;
  logic xValid, yValid, histogramCleared;
  modport master(
    input frameStart, pixelValid, pixelData, filterXAddr, filterYAddr, filterDone,
          xValid, yValid, histogramCleared,
    output busy, frameDone, timeoutError, overrun, memXAddress, memYAddress, memWrite,
           memDataIn, filterStart, readHistogram, clearHistogram
  );
  modport slave(
    output frameStart, pixelValid, pixelData, filterXAddr, filterYAddr, filterDone,
           xValid, yValid, histogramCleared,
    input busy, frameDone, timeoutError, overrun, memXAddress, memYAddress, memWrite,
          memDataIn, filterStart, readHistogram, clearHistogram
  );
endinterface

// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: per-frame sequencer for pixel load, median filter, histogram readout and clear.
// Ports: clk, reset (async, active-high), bus (median_frame_ctrl_if.master).
module median_frame_ctrl #(
  parameter int X_SIZE  = 240,
  parameter int Y_SIZE  = 180,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 5000000
) (
  input logic clk,
  input logic reset,
  median_frame_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int XW = $clog2(X_SIZE + 1);
  localparam int YW = $clog2(Y_SIZE + 1);
  typedef enum logic [2:0] {IDLE, LOAD, FILTER, READOUT, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] x_cnt, y_cnt;
  logic [XW-1:0] xr_cnt, xr_nx;
  logic [YW-1:0] yr_cnt, yr_nx;
  logic [TW-1:0] wait_cnt;
  logic timeout_err, ovr, pix, last_pix, expired, start;
  assign start = bus.frameStart;
  always_comb begin
    pix = state == LOAD && bus.pixelValid;
    last_pix = pix && x_cnt == ADDR_W'(X_SIZE - 1) && y_cnt == ADDR_W'(Y_SIZE - 1);
    // the count reaches TIMEOUT on the edge that ends this cycle
    expired = wait_cnt >= TW'(TIMEOUT - 1);
    xr_nx = xr_cnt + XW'(bus.xValid && xr_cnt != XW'(X_SIZE));
    yr_nx = yr_cnt + YW'(bus.yValid && yr_cnt != YW'(Y_SIZE));
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = last_pix ? FILTER : LOAD;
      FILTER:  state_nx = bus.filterDone ? READOUT : expired ? CLEAR : FILTER;
      READOUT: state_nx = (xr_nx == XW'(X_SIZE) && yr_nx == YW'(Y_SIZE)) ? CLEAR : READOUT;
      CLEAR:   state_nx = (bus.histogramCleared || expired) ? DONE : CLEAR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
      xr_cnt <= '0;
      yr_cnt <= '0;
      wait_cnt <= '0;
      timeout_err <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_nx;
      wait_cnt <= (state_nx == state && (state == FILTER || state == CLEAR)) ? wait_cnt + 1'b1 : '0;
      xr_cnt <= state == READOUT ? xr_nx : '0;
      yr_cnt <= state == READOUT ? yr_nx : '0;
      if (state == IDLE) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (pix) begin
        y_cnt <= y_cnt == ADDR_W'(Y_SIZE - 1) ? '0 : y_cnt + 1'b1;
        x_cnt <= y_cnt == ADDR_W'(Y_SIZE - 1) ? x_cnt + 1'b1 : x_cnt;
      end
      if (state == IDLE && start) timeout_err <= 1'b0;
      else if (expired && ((state == FILTER && !bus.filterDone) ||
                           (state == CLEAR && !bus.histogramCleared))) timeout_err <= 1'b1;
      if (start) ovr <= state != IDLE;
      else ovr <= ovr;
    end
  assign bus.busy = state != IDLE;
  assign bus.frameDone = state == DONE;
  assign bus.timeoutError = timeout_err;
  assign bus.overrun = ovr;
  assign bus.memWrite = pix;
  assign bus.memDataIn = state == LOAD && bus.pixelData;
  assign bus.memXAddress = state == LOAD ? x_cnt : state == FILTER ? bus.filterXAddr : '0;
  assign bus.memYAddress = state == LOAD ? y_cnt : state == FILTER ? bus.filterYAddr : '0;
  assign bus.filterStart = state == FILTER;
  assign bus.readHistogram = state == READOUT;
  // wait_cnt is zero only in the first cycle after entering CLEAR
  assign bus.clearHistogram = state == CLEAR && wait_cnt == '0;
endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb_median_frame_ctrl: directed table-driven bench for median_frame_ctrl with a 4x3 image and TIMEOUT=16.
module tb_median_frame_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int pass = 0;
  median_frame_ctrl_if #(.ADDR_W(8)) bus();
  median_frame_ctrl #(.X_SIZE(4), .Y_SIZE(3), .ADDR_W(8), .TIMEOUT(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    string name;
    logic [6:0] in;
    logic [7:0] fx, fy;
    logic [24:0] exp;
  } vec_t;
  vec_t tbl[$];
  // flag order: busy, frameDone, timeoutError, overrun, memWrite, memDataIn, filterStart, readHistogram, clearHistogram
  function automatic logic [24:0] e(logic [8:0] f, logic [7:0] mx, logic [7:0] my);
    return {f, mx, my};
  endfunction
  function automatic logic [24:0] outs();
    return {bus.busy, bus.frameDone, bus.timeoutError, bus.overrun, bus.memWrite, bus.memDataIn,
            bus.filterStart, bus.readHistogram, bus.clearHistogram, bus.memXAddress, bus.memYAddress};
  endfunction
  task automatic add(string n, logic [6:0] in, logic [7:0] fx, logic [7:0] fy, logic [24:0] ex);
    vec_t v;
    v.name = n;
    v.in = in;
    v.fx = fx;
    v.fy = fy;
    v.exp = ex;
    tbl.push_back(v);
  endtask
  // in bits: frameStart, pixelValid, pixelData, filterDone, xValid, yValid, histogramCleared
  task automatic step(logic [6:0] in, logic [7:0] fx, logic [7:0] fy);
    @(negedge clk);
    {bus.frameStart, bus.pixelValid, bus.pixelData, bus.filterDone, bus.xValid, bus.yValid,
     bus.histogramCleared} = in;
    bus.filterXAddr = fx;
    bus.filterYAddr = fy;
    #1;
  endtask
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  initial begin
    logic [11:0] pat;
    logic o;
    pat = 12'b1011_0010_1101;
    o = 1'b0;
    {bus.frameStart, bus.pixelValid, bus.pixelData, bus.filterDone, bus.xValid, bus.yValid,
     bus.histogramCleared} = '0;
    bus.filterXAddr = '0;
    bus.filterYAddr = '0;
    add("idle_start", 7'b1000000, 0, 0, e(9'b0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      add($sformatf("load%0d", i), {2'b01, pat[i], 4'b0}, 0, 0,
          e({3'b100, o, 1'b1, pat[i], 3'b000}, 8'(i / 3), 8'(i % 3)));
      if (i == 2 || i == 5 || i == 8) begin
        add($sformatf("gap%0d", i), {i == 5, 6'b0}, 0, 0,
            e({3'b100, o, 5'b00000}, 8'((i + 1) / 3), 8'((i + 1) % 3)));
        if (i == 5) o = 1'b1;
      end
    end
    add("filt0", 7'b0000000, 5, 7, e(9'b100100100, 5, 7));
    add("filt_done", 7'b0001000, 5, 7, e(9'b100100100, 5, 7));
    add("rd_xy1", 7'b0000110, 0, 0, e(9'b100100010, 0, 0));
    add("rd_xy2", 7'b0000110, 0, 0, e(9'b100100010, 0, 0));
    add("rd_x3", 7'b0000100, 0, 0, e(9'b100100010, 0, 0));
    add("rd_idle", 7'b0000000, 0, 0, e(9'b100100010, 0, 0));
    add("rd_y3", 7'b0000010, 0, 0, e(9'b100100010, 0, 0));
    add("rd_y_extra", 7'b0000010, 0, 0, e(9'b100100010, 0, 0));
    add("rd_x4", 7'b0000100, 0, 0, e(9'b100100010, 0, 0));
    add("clr0", 7'b0000000, 0, 0, e(9'b100100001, 0, 0));
    add("clr1", 7'b0000000, 0, 0, e(9'b100100000, 0, 0));
    add("clr2_ack", 7'b0000001, 0, 0, e(9'b100100000, 0, 0));
    add("done_fs", 7'b1000000, 0, 0, e(9'b110100000, 0, 0));
    add("idle_after", 7'b0000000, 0, 0, e(9'b000100000, 0, 0));
    #3;
    chk("reset_state", 32'(outs()), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[i]) begin
      step(tbl[i].in, tbl[i].fx, tbl[i].fy);
      chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
    end
    step(7'b1000000, 0, 0);
    step(7'b0100000, 0, 0);
    chk("ovr_cleared", {bus.busy, bus.overrun, bus.memWrite}, 3'b101);
    for (int i = 1; i < 12; i++) step(7'b0100000, 0, 0);
    for (int i = 0; i < 16; i++) step(7'b0000000, 0, 0);
    chk("to_filter_last", {bus.filterStart, bus.timeoutError}, 2'b10);
    step(7'b0000000, 0, 0);
    chk("to_flag", {bus.filterStart, bus.timeoutError, bus.clearHistogram, bus.busy}, 4'b0111);
    for (int i = 0; i < 15; i++) step(7'b0000000, 0, 0);
    chk("to_clear_last", {bus.clearHistogram, bus.frameDone, bus.timeoutError}, 3'b001);
    step(7'b0000000, 0, 0);
    chk("to_done", {bus.frameDone, bus.busy, bus.timeoutError}, 3'b111);
    step(7'b0000000, 0, 0);
    chk("to_idle_sticky", {bus.frameDone, bus.busy, bus.timeoutError}, 3'b001);
    step(7'b1000000, 0, 0);
    step(7'b0110000, 0, 0);
    chk("terr_cleared", {bus.timeoutError, bus.memDataIn}, 2'b01);
    for (int i = 1; i < 12; i++) step(7'b0100000, 0, 0);
    step(7'b0000000, 5, 7);
    chk("rst_pre_filter", {bus.filterStart, bus.memXAddress, bus.memYAddress}, {1'b1, 8'd5, 8'd7});
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", 32'(outs()), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(7'b1000000, 0, 0);
    step(7'b0100000, 0, 0);
    chk("restart_addr0", {bus.memWrite, bus.memXAddress, bus.memYAddress}, {1'b1, 8'd0, 8'd0});
    step(7'b0100000, 0, 0);
    chk("restart_addr1", {bus.memWrite, bus.memXAddress, bus.memYAddress}, {1'b1, 8'd0, 8'd1});
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/median_frame_ctrl.md
Name: median_frame_ctrl

Overview:
- Frame-level sequencer around histogramTop and the binary-image flatMem.
- Per frame, it:
  - writes an incoming raster pixel stream into the binary-image memory;
  - starts the median filter and owns the memory address mux between loader and filter;
  - sequences histogram readout and clearing;
  - reports frame completion.
- It replaces the ad-hoc glue logic around the filter and memories.

Parameters:
X_SIZE, 240, image width (x address range 0..X_SIZE-1)
Y_SIZE, 180, image height (y address range 0..Y_SIZE-1)
ADDR_W, 8, width of x/y addresses
TIMEOUT, 5000000, max cycles waiting on filterDone or histogramCleared (counter width 23)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
frameStart  in  1  1-cycle request to process a new frame
pixelValid  in  1  pixel stream qualifier
pixelData  in  1  binary pixel value
busy  out  1  high in any state except IDLE
frameDone  out  1  1-cycle pulse, frame fully processed
timeoutError  out  1  sticky, wait exceeded TIMEOUT
overrun  out  1  sticky, frameStart received while busy
memXAddress  out  ADDR_W  binary memory x address
memYAddress  out  ADDR_W  binary memory y address
memWrite  out  1  binary memory write enable
memDataIn  out  1  binary memory write data
filterXAddr  in  ADDR_W  filter x read address (xAddressOut)
filterYAddr  in  ADDR_W  filter y read address (yAddressOut)
filterStart  out  1  level start to histogramTop
filterDone  in  1  filter finished
readHistogram  out  1  histogram readout enable
clearHistogram  out  1  histogram clear request
xValid  in  1  x histogram bin valid
yValid  in  1  y histogram bin valid
histogramCleared  in  1  clear complete

Behaviour:
- Reset: every output is 0; state IDLE; all counters 0.
- States: IDLE, LOAD, FILTER, READOUT, CLEAR, DONE.
- IDLE:
  - frameStart -> LOAD.
  - Clears timeoutError and overrun on that accepted start.
  - Loader counters xCnt and yCnt are set to 0.
- LOAD:
  - memWrite = pixelValid (combinational); memDataIn = pixelData.
  - memXAddress = xCnt; memYAddress = yCnt.
  - Each accepted pixel:
    - yCnt increments;
    - when yCnt = Y_SIZE-1 it wraps to 0 and xCnt increments (y inner, x outer).
  - Pixel at (X_SIZE-1, Y_SIZE-1) accepted -> FILTER next cycle.
  - No pixels are accepted outside LOAD. memWrite = 0 in all other states.
- FILTER:
  - filterStart = 1 (registered, rises the cycle after the last pixel).
  - memXAddress/memYAddress = filterXAddr/filterYAddr (combinational pass-through).
  - filterDone = 1 -> READOUT, and filterStart drops the same edge.
  - Wait counter reaches TIMEOUT without filterDone:
    - timeoutError = 1;
    - filterStart drops;
    - -> CLEAR (histogram is still cleared).
- READOUT:
  - readHistogram = 1.
  - Counts xValid beats to X_SIZE and yValid beats to Y_SIZE. xValid and yValid in the same cycle both count.
  - Counting stops at each limit; extra beats are ignored.
  - Both counts reached -> CLEAR; readHistogram drops the same edge.
- CLEAR:
  - clearHistogram = 1 for exactly the first cycle in the state.
  - Then waits for histogramCleared -> DONE.
  - histogramCleared in the first CLEAR cycle is accepted.
  - Timeout -> timeoutError = 1, -> DONE.
- DONE: frameDone = 1 for one cycle -> IDLE.
- Address outputs in IDLE/READOUT/CLEAR/DONE: 0.
- frameStart in any non-IDLE state: ignored, sets overrun. frameStart in the same cycle as the DONE->IDLE edge is ignored.
- Reset mid-operation: immediate return to IDLE; all outputs 0; no frameDone.
- Wait counter: cleared on each state entry, 1 per cycle in FILTER/CLEAR, compare >= TIMEOUT.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 before next clk edge; busy = 0.
- Full load, X_SIZE=4, Y_SIZE=3:
  - Stimulus: frameStart, then 12 pixelValid beats with gaps.
  - memWrite high on exactly 12 cycles; addresses sequence (0,0),(0,1),(0,2),(1,0)...(3,2); memDataIn equals pixelData.
  - filterStart rises 1 cycle after the 12th beat.
- Filter and readout:
  - FILTER phase: drive filterXAddr=5, filterYAddr=7 -> memXAddress=5, memYAddress=7.
  - filterDone -> readHistogram=1 next cycle.
  - 4 xValid + 3 yValid (two coincident) -> readHistogram drops.
  - Single clearHistogram pulse; histogramCleared 2 cycles later -> frameDone pulse 1 cycle after.
- Timeout, TIMEOUT=16: no filterDone -> timeoutError=1 at wait count 16; clearHistogram pulses; with no histogramCleared, frameDone follows 16 cycles later.
- Overrun: frameStart during LOAD -> overrun=1; load continues unaffected; next accepted frameStart clears overrun.
- Reset in FILTER: filterStart and busy go to 0 immediately; a following frameStart restarts LOAD at address (0,0).
